// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Operand width used when the instantiating code does not override it.
    localparam int unsigned MULT_WIDTH_DEFAULT = 32'd8;

    // Bit counter width: $clog2(WIDTH), never narrower than one bit.
    function automatic int unsigned mult_cnt_w(input int unsigned width);
        if (width < 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Controller for the shift-add multiplier: FSM, bit counter, busy/done and
// the load/step/finish strobes that drive the datapath in the top.
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic start,
    output logic load,
    output logic step,
    output logic finish,
    output logic busy,
    output logic done
);

    localparam int unsigned CNT_W = mult_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    mult_state_t      state_r;
    mult_state_t      state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             step_s;
    logic             finish_s;

    // Next-state, counter update and datapath strobes.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        load_s   = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                    cnt_s   = CNT_LOAD;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == CNT_ZERO) begin
                    state_s  = DONE;
                    finish_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered busy/done, all cleared by reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    assign load   = load_s;
    assign step   = step_s;
    assign finish = finish_s;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with
// optional two's-complement operands handled by sign-magnitude correction.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH     = MULT_WIDTH_DEFAULT,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]     ZERO_W1 = {(WIDTH+1){1'b0}};

    logic                 load_s;
    logic                 step_s;
    logic                 finish_s;
    logic                 busy_s;
    logic                 done_s;

    logic                 signed_eff_s;
    logic                 neg_s;
    logic [WIDTH-1:0]     x_mag_s;
    logic [WIDTH-1:0]     y_mag_s;
    logic [WIDTH:0]       addend_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   raw_s;
    logic [2*WIDTH-1:0]   result_s;

    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     mplr_r;
    logic [WIDTH:0]       acc_hi_r;
    logic                 neg_r;
    logic [2*WIDTH-1:0]   product_r;

    seq_mult_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .start  (start),
        .load   (load_s),
        .step   (step_s),
        .finish (finish_s),
        .busy   (busy_s),
        .done   (done_s)
    );

    // Operand magnitudes and result sign; signed mode vanishes when disabled.
    always_comb begin
        if (SIGNED_EN != 1'b0) begin
            signed_eff_s = is_signed;
        end else begin
            signed_eff_s = 1'b0;
        end
        if (signed_eff_s && x[WIDTH-1]) begin
            x_mag_s = (~x) + ONE_W;
        end else begin
            x_mag_s = x;
        end
        if (signed_eff_s && y[WIDTH-1]) begin
            y_mag_s = (~y) + ONE_W;
        end else begin
            y_mag_s = y;
        end
        neg_s = signed_eff_s & (x[WIDTH-1] ^ y[WIDTH-1]);
    end

    // One add-and-shift step; raw_s is the full product after this step.
    always_comb begin
        if (mplr_r[0]) begin
            addend_s = {1'b0, mcand_r};
        end else begin
            addend_s = ZERO_W1;
        end
        sum_s = acc_hi_r + addend_s;
        raw_s = {sum_s, mplr_r[WIDTH-1:1]};
        if (neg_r) begin
            result_s = (~raw_s) + ONE_2W;
        end else begin
            result_s = raw_s;
        end
    end

    // Operand capture, accumulate/shift, and product write on the last step.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mcand_r   <= {WIDTH{1'b0}};
            mplr_r    <= {WIDTH{1'b0}};
            acc_hi_r  <= ZERO_W1;
            neg_r     <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else if (load_s) begin
            mcand_r  <= x_mag_s;
            mplr_r   <= y_mag_s;
            acc_hi_r <= ZERO_W1;
            neg_r    <= neg_s;
        end else if (step_s) begin
            acc_hi_r <= {1'b0, sum_s[WIDTH:1]};
            mplr_r   <= {sum_s[0], mplr_r[WIDTH-1:1]};
            if (finish_s) begin
                product_r <= result_s;
            end
        end
    end

    assign busy    = busy_s;
    assign done    = done_s;
    assign product = product_r;

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier, the next-generation replacement for the fixed 4-bit multiplier and its separate controller. It multiplies two WIDTH-bit operands, unsigned or two's-complement selected per operation, and retires one multiplier bit per clock. A start/busy/done handshake lets a host sequencer issue back-to-back operations.

## Interface
- WIDTH, default 8: operand width; legal range 2..32.
- SIGNED_EN, default 1: 1 enables the signed mode; 0 ties signed mode off and removes the sign-correction logic.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous and active-high.
- start  input  1  request; accepted only when busy=0.
- is_signed  input  1  operand format, sampled with start: 1 = two's complement, 0 = unsigned. Ignored when SIGNED_EN=0.
- x  input  WIDTH  multiplicand, sampled with start.
- y  input  WIDTH  multiplier, sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; product is valid in this cycle.
- product  output  2*WIDTH  result, held stable from done until the next accepted start.

## Operation
- Reset values: state IDLE; busy=0, done=0, product=0; internal operands and counter cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE when the bit counter reaches 0.
  - DONE -> IDLE unconditionally.
- Load, on the accepting edge:
  - Capture the magnitudes |x| and |y|, each as an unsigned WIDTH-bit value. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits.
  - Capture neg = is_signed & (x[MSB] ^ y[MSB]).
  - Clear the accumulator. Load the counter with WIDTH-1.
- Each RUN cycle:
  - If the multiplier LSB is 1, add the multiplicand to the upper accumulator half. The upper half is WIDTH+1 bits so the carry is kept.
  - Shift {carry, acc, multiplier} right by one.
  - Decrement the counter.
  - Add and shift complete in the same cycle, with no separate phases and no negedge logic.
- Final RUN edge: write the result to product, two's-complement negated if neg=1.
- In unsigned mode, or with SIGNED_EN=0, the result is the raw 2*WIDTH-bit product.
- start while busy=1 is ignored; operands are not re-sampled.
- start in the DONE cycle is ignored.
- Reset asserted mid-operation aborts immediately: return to IDLE, clear product, and issue no done pulse.

## Timing
- The start sampled at edge 0 gives RUN during cycles 1..WIDTH.
- done=1 and product valid in cycle WIDTH+1, i.e. latency WIDTH+1 clocks from the accepting edge.
- The earliest next start is accepted at the edge ending the DONE cycle's successor (IDLE). The initiation interval is WIDTH+2 clocks.
- busy rises the cycle after acceptance and falls on entry to IDLE.
- product changes only on the final RUN edge and on reset.

## Structure
- Package mult_pkg holds:
  - mult_state_t, a 2-bit enum: IDLE, RUN, DONE.
  - The localparam for the counter width, $clog2(WIDTH).
- Sub-module seq_mult_ctrl contains the FSM, the counter, and the busy/done generation. It exposes load, step and finish strobes.
- The datapath (magnitude, accumulate/shift, sign fix) stays in the top.

## Test plan
- WIDTH=4, unsigned, x=13, y=11 -> product=143 (0x8F); done exactly 5 cycles after the accepting edge; busy high for 5 cycles.
- WIDTH=8, signed, x=-128, y=-128 -> product=16384 (0x4000). WIDTH=8, signed, x=-3, y=7 -> product=0xFFEB (-21).
- WIDTH=8, unsigned, x=0xFF, y=0xFF -> product=0xFE01. Also x=0 with any y -> product=0.
- Back-to-back operations: second start held high throughout the first operation -> ignored until IDLE. The second result is correct, and the first product stays stable until the second is accepted.
- Reset asserted in RUN cycle 3, x=9, y=6 -> busy=0, done=0, product=0 immediately. A new start after release gives product=54.
- SIGNED_EN=0, is_signed=1, x=0xF0, y=0x02 (WIDTH=8) -> product=0x01E0, treated as unsigned.
